seven_segment_scanner: RTL and testbench

- Downstream display stage: consumes a packed 8-digit hex value and time-multiplexes it across the Nexys4 DDR 8-digit common-anode display.
- Every pattern it drives is active-low.
- Holds a frame-buffered copy of its inputs, so the value shown cannot tear mid-scan.
- Provides a one-cycle frame strobe for upstream animation logic.

---
 rtl/seven_segment_scanner_if.sv | 27 ++
 rtl/seven_segment_scanner.sv | 124 ++++++++++++
 tb/tb_seven_segment_scanner.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
// Display bus between an upstream value source and the seven-segment scanner.
// The master drives the value to show; the slave drives the display pins.
interface seven_segment_scanner_if;
  logic [31:0] number;
  logic [7:0]  digit_enable;
  logic [7:0]  dots;
  logic        seg_a;
  logic        seg_b;
  logic        seg_c;
  logic        seg_d;
  logic        seg_e;
  logic        seg_f;
  logic        seg_g;
  logic        seg_dp;
  logic [7:0]  anodes;
  logic        frame_start;

  modport master (
    output number, digit_enable, dots,
    input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_dp, anodes, frame_start
  );

  modport slave (
    input  number, digit_enable, dots,
    output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_dp, anodes, frame_start
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Frame-buffered, time-multiplexed driver for an 8-digit common-anode display (active-low pins).
// Optional anti-ghosting blank at the start of each slot: SEVEN_SEGMENT_SCANNER_BLANKING_GAP_EN.
module seven_segment_scanner #(
  parameter int digit_count   = 8,
  parameter int refresh_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  seven_segment_scanner_if.slave bus
);
  localparam logic [2:0] last_index = 3'(digit_count - 1);

  logic [refresh_width-1:0] prescaler_q, prescaler_d;
  logic [2:0]               index_q, index_d;
  logic [31:0]              shadow_number_q, shadow_number_d;
  logic [7:0]               shadow_enable_q, shadow_enable_d;
  logic [7:0]               shadow_dots_q, shadow_dots_d;
  logic                     load_pending_q;
  logic [7:0]               anodes_q, anodes_d;
  logic [6:0]               seg_q, seg_d;
  logic                     seg_dp_q, seg_dp_d;
  logic                     frame_start_q;

  logic       slot_end;
  logic       frame_wrap;
  logic       load;
  logic       blank;
  logic [7:0] digit_lit;
  logic [3:0] nibble;
  logic [6:0] pattern;

  assign slot_end   = &prescaler_q;
  assign frame_wrap = slot_end && (index_q == last_index);
  assign load       = load_pending_q || frame_wrap;
  assign nibble     = shadow_number_q[{index_q, 2'b00} +: 4];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_anode
      if (gi < digit_count) begin : g_live
        assign digit_lit[gi] = (index_q == 3'(gi)) && shadow_enable_q[gi];
      end else begin : g_off
        assign digit_lit[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef SEVEN_SEGMENT_SCANNER_BLANKING_GAP_EN
  assign blank = (prescaler_q[refresh_width-1 -: 4] == 4'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    // The prescaler holds on the priming load so the first frame has full-length slots.
    prescaler_d     = load_pending_q ? prescaler_q : prescaler_q + 1'b1;
    index_d         = index_q;
    if (slot_end) begin
      index_d = frame_wrap ? 3'd0 : index_q + 3'd1;
    end
    shadow_number_d = load ? bus.number       : shadow_number_q;
    shadow_enable_d = load ? bus.digit_enable : shadow_enable_q;
    shadow_dots_d   = load ? bus.dots         : shadow_dots_q;

    pattern = 7'b0000000;
    case (nibble)
      4'h0: pattern = 7'b1111110;
      4'h1: pattern = 7'b0110000;
      4'h2: pattern = 7'b1101101;
      4'h3: pattern = 7'b1111001;
      4'h4: pattern = 7'b0110011;
      4'h5: pattern = 7'b1011011;
      4'h6: pattern = 7'b1011111;
      4'h7: pattern = 7'b1110000;
      4'h8: pattern = 7'b1111111;
      4'h9: pattern = 7'b1111011;
      4'hA: pattern = 7'b1110111;
      4'hB: pattern = 7'b0011111;
      4'hC: pattern = 7'b1001110;
      4'hD: pattern = 7'b0111101;
      4'hE: pattern = 7'b1001111;
      default: pattern = 7'b1000111;
    endcase
    seg_d    = ~pattern;
    seg_dp_d = ~shadow_dots_q[index_q];
    anodes_d = blank ? 8'hFF : ~digit_lit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q     <= '0;
      index_q         <= 3'd0;
      shadow_number_q <= 32'd0;
      shadow_enable_q <= 8'd0;
      shadow_dots_q   <= 8'd0;
      load_pending_q  <= 1'b1;
      anodes_q        <= 8'hFF;
      seg_q           <= 7'h7F;
      seg_dp_q        <= 1'b1;
      frame_start_q   <= 1'b0;
    end else begin
      prescaler_q     <= prescaler_d;
      index_q         <= index_d;
      shadow_number_q <= shadow_number_d;
      shadow_enable_q <= shadow_enable_d;
      shadow_dots_q   <= shadow_dots_d;
      load_pending_q  <= 1'b0;
      anodes_q        <= anodes_d;
      seg_q           <= seg_d;
      seg_dp_q        <= seg_dp_d;
      frame_start_q   <= load;
    end
  end

  assign bus.seg_a       = seg_q[6];
  assign bus.seg_b       = seg_q[5];
  assign bus.seg_c       = seg_q[4];
  assign bus.seg_d       = seg_q[3];
  assign bus.seg_e       = seg_q[2];
  assign bus.seg_f       = seg_q[1];
  assign bus.seg_g       = seg_q[0];
  assign bus.seg_dp      = seg_dp_q;
  assign bus.anodes      = anodes_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized bench for seven_segment_scanner: three instances (8, 3 and 1 digits, 32-clock slots)
// checked every cycle against a cycle-count model of slot/frame arithmetic.
module tb_seven_segment_scanner;
  localparam int RW = 5;
  localparam int S  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] number = 32'h89ABCDEF;
  logic [7:0]  digit_enable = 8'hFF;
  logic [7:0]  dots = 8'h00;

  always #5 clk = ~clk;

  seven_segment_scanner_if bus8 ();
  seven_segment_scanner_if bus3 ();
  seven_segment_scanner_if bus1 ();

  assign bus8.number = number; assign bus8.digit_enable = digit_enable; assign bus8.dots = dots;
  assign bus3.number = number; assign bus3.digit_enable = digit_enable; assign bus3.dots = dots;
  assign bus1.number = number; assign bus1.digit_enable = digit_enable; assign bus1.dots = dots;

  seven_segment_scanner #(.digit_count(8), .refresh_width(RW)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  seven_segment_scanner #(.digit_count(3), .refresh_width(RW)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
  seven_segment_scanner #(.digit_count(1), .refresh_width(RW)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [7:0] anodes_obs [3];
  logic [6:0] seg_obs [3];
  logic       dp_obs [3];
  logic       fs_obs [3];

  assign anodes_obs[0] = bus8.anodes;
  assign anodes_obs[1] = bus3.anodes;
  assign anodes_obs[2] = bus1.anodes;
  assign seg_obs[0] = {bus8.seg_a, bus8.seg_b, bus8.seg_c, bus8.seg_d, bus8.seg_e, bus8.seg_f, bus8.seg_g};
  assign seg_obs[1] = {bus3.seg_a, bus3.seg_b, bus3.seg_c, bus3.seg_d, bus3.seg_e, bus3.seg_f, bus3.seg_g};
  assign seg_obs[2] = {bus1.seg_a, bus1.seg_b, bus1.seg_c, bus1.seg_d, bus1.seg_e, bus1.seg_f, bus1.seg_g};
  assign dp_obs[0] = bus8.seg_dp;
  assign dp_obs[1] = bus3.seg_dp;
  assign dp_obs[2] = bus1.seg_dp;
  assign fs_obs[0] = bus8.frame_start;
  assign fs_obs[1] = bus3.frame_start;
  assign fs_obs[2] = bus1.frame_start;

  int dcs [3] = '{8, 3, 1};
  logic [6:0] dec_tab [16];

  // Model: t counts clocks since reset release; shadow copies are taken on the load clocks.
  int          t = 0;
  logic [31:0] m_num [3];
  logic [7:0]  m_en [3];
  logic [7:0]  m_dots [3];
  logic [7:0]  exp_an [3];
  logic [6:0]  exp_seg [3];
  logic        exp_dp [3];
  logic        exp_fs [3];

  int n_checks = 0;
  int n_fail = 0;

  task automatic step();
    if (reset) begin
      t = 0;
      for (int k = 0; k < 3; k++) begin
        m_num[k] = 32'd0; m_en[k] = 8'd0; m_dots[k] = 8'd0;
        exp_an[k] = 8'hFF; exp_seg[k] = 7'h7F; exp_dp[k] = 1'b1; exp_fs[k] = 1'b0;
      end
    end else begin
      t++;
      for (int k = 0; k < 3; k++) begin
        int pres;
        int dig;
        logic [3:0] nib;
        pres = (t == 1) ? 0 : (t - 2) % S;
        dig  = (t == 1) ? 0 : ((t - 2) / S) % dcs[k];
        nib  = m_num[k][dig*4 +: 4];
        exp_an[k] = 8'hFF;
        if (m_en[k][dig]) exp_an[k][dig] = 1'b0;
`ifdef SEVEN_SEGMENT_SCANNER_BLANKING_GAP_EN
        if (pres < S / 16) exp_an[k] = 8'hFF;
`else
        if (pres < 0) exp_an[k] = 8'hFF;
`endif
        exp_seg[k] = ~dec_tab[nib];
        exp_dp[k]  = ~m_dots[k][dig];
        exp_fs[k]  = ((t - 1) % (dcs[k] * S)) == 0;
        if (exp_fs[k]) begin
          m_num[k] = number; m_en[k] = digit_enable; m_dots[k] = dots;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; number = 32'h89ABCDEF; digit_enable = 8'hFF; dots = 8'h00;
    repeat (3) begin
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({anodes_obs[k], seg_obs[k], dp_obs[k], fs_obs[k]} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL reset dc=%0d: got an=%h seg=%b dp=%b fs=%b, expected an=ff seg=1111111 dp=1 fs=0",
                   dcs[k], anodes_obs[k], seg_obs[k], dp_obs[k], fs_obs[k]);
        end
      end
    end
    $display("reset: checked 3 clocks in reset");
  endtask

  task automatic test_first_load();
    reset = 1'b0;
    step();
    n_checks++;
    if (fs_obs[0] !== 1'b1) begin
      n_fail++; $display("FAIL first_frame_start: got %b expected 1", fs_obs[0]);
    end
    step();
    n_checks++;
    if (seg_obs[0] !== ~7'b1000111) begin
      n_fail++; $display("FAIL first_digit_F: got %b expected %b", seg_obs[0], ~7'b1000111);
    end
`ifndef SEVEN_SEGMENT_SCANNER_BLANKING_GAP_EN
    n_checks++;
    if (anodes_obs[0] !== 8'hFE) begin
      n_fail++; $display("FAIL first_anodes: got %h expected fe", anodes_obs[0]);
    end
`endif
    $display("first_load: t=%0d an=%h seg=%b", t, anodes_obs[0], seg_obs[0]);
  endtask

  task automatic test_scan_order();
    int p8 = -1;
    int p3 = -1;
    while (t < 600) begin
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({anodes_obs[k], seg_obs[k], dp_obs[k], fs_obs[k]} !== {exp_an[k], exp_seg[k], exp_dp[k], exp_fs[k]}) begin
          n_fail++;
          $display("FAIL scan dc=%0d t=%0d: got an=%h seg=%b dp=%b fs=%b, expected an=%h seg=%b dp=%b fs=%b",
                   dcs[k], t, anodes_obs[k], seg_obs[k], dp_obs[k], fs_obs[k],
                   exp_an[k], exp_seg[k], exp_dp[k], exp_fs[k]);
        end
      end
      if (fs_obs[0] && p8 < 0) p8 = t;
      if (fs_obs[1] && p3 < 0) p3 = t;
      if (t == 2 + 32*3 + 5) begin
        n_checks++;
        if ({anodes_obs[0], seg_obs[0]} !== {8'hF7, ~7'b1001110}) begin
          n_fail++; $display("FAIL digit3_C: got an=%h seg=%b expected an=f7 seg=%b",
                             anodes_obs[0], seg_obs[0], ~7'b1001110);
        end
      end
    end
    n_checks++;
    if (p8 - 1 !== 256) begin
      n_fail++; $display("FAIL frame_period_8: got %0d expected 256", p8 - 1);
    end
    n_checks++;
    if (p3 - 1 !== 96) begin
      n_fail++; $display("FAIL frame_period_3: got %0d expected 96", p3 - 1);
    end
    $display("scan_order: frame periods 8-digit=%0d 3-digit=%0d", p8 - 1, p3 - 1);
  endtask

  task automatic test_tearing();
    number = 32'h89ABCDEF; digit_enable = 8'hFF; dots = 8'h00;
    restart();
    while (t < 300) begin
      if (t == 134) number = 32'd0;
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({anodes_obs[k], seg_obs[k], dp_obs[k], fs_obs[k]} !== {exp_an[k], exp_seg[k], exp_dp[k], exp_fs[k]}) begin
          n_fail++;
          $display("FAIL tearing dc=%0d t=%0d: got an=%h seg=%b fs=%b, expected an=%h seg=%b fs=%b",
                   dcs[k], t, anodes_obs[k], seg_obs[k], fs_obs[k], exp_an[k], exp_seg[k], exp_fs[k]);
        end
      end
      if (t == 2 + 32*6 + 3 || t == 257) begin
        n_checks++;
        if (seg_obs[0] !== ~dec_tab[(t == 257) ? 8 : 9]) begin
          n_fail++; $display("FAIL tearing_old_value t=%0d: got %b expected %b",
                             t, seg_obs[0], ~dec_tab[(t == 257) ? 8 : 9]);
        end
      end
      if (t == 258) begin
        n_checks++;
        if (seg_obs[0] !== ~7'b1111110) begin
          n_fail++; $display("FAIL tearing_new_value: got %b expected %b", seg_obs[0], ~7'b1111110);
        end
      end
    end
    $display("tearing: number cleared mid-frame, t=%0d", t);
  endtask

  task automatic test_enables_dots();
    number = $urandom; digit_enable = 8'h05; dots = 8'h04;
    restart();
    while (t < 300) begin
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({anodes_obs[k], seg_obs[k], dp_obs[k], fs_obs[k]} !== {exp_an[k], exp_seg[k], exp_dp[k], exp_fs[k]}) begin
          n_fail++;
          $display("FAIL enables dc=%0d t=%0d: got an=%h dp=%b, expected an=%h dp=%b",
                   dcs[k], t, anodes_obs[k], dp_obs[k], exp_an[k], exp_dp[k]);
        end
      end
      n_checks++;
      if (!(anodes_obs[0] inside {8'hFF, 8'hFE, 8'hFB})) begin
        n_fail++; $display("FAIL enables_anode_set t=%0d: got %h expected ff/fe/fb", t, anodes_obs[0]);
      end
`ifndef SEVEN_SEGMENT_SCANNER_BLANKING_GAP_EN
      if (t >= 2) begin
        n_checks++;
        if ((dp_obs[0] == 1'b0) !== (anodes_obs[0] == 8'hFB)) begin
          n_fail++; $display("FAIL dots_only_digit2 t=%0d: got dp=%b an=%h expected dp low exactly when an=fb",
                             t, dp_obs[0], anodes_obs[0]);
        end
      end
`endif
    end
    $display("enables_dots: enable=05 dots=04 over %0d clocks", t);
  endtask

  task automatic test_mid_frame_reset();
    number = $urandom; digit_enable = 8'hFF; dots = $urandom;
    restart();
    while (t < 2 + 32*5 + 10) begin
      step();
    end
    reset = 1'b1;
    step();
    n_checks++;
    if ({anodes_obs[0], seg_obs[0], dp_obs[0], fs_obs[0]} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL mid_frame_reset: got an=%h seg=%b dp=%b fs=%b expected an=ff seg=1111111 dp=1 fs=0",
                         anodes_obs[0], seg_obs[0], dp_obs[0], fs_obs[0]);
    end
    reset = 1'b0;
    repeat (40) begin
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({anodes_obs[k], seg_obs[k], dp_obs[k], fs_obs[k]} !== {exp_an[k], exp_seg[k], exp_dp[k], exp_fs[k]}) begin
          n_fail++;
          $display("FAIL after_reset dc=%0d t=%0d: got an=%h seg=%b fs=%b, expected an=%h seg=%b fs=%b",
                   dcs[k], t, anodes_obs[k], seg_obs[k], fs_obs[k], exp_an[k], exp_seg[k], exp_fs[k]);
        end
      end
`ifndef SEVEN_SEGMENT_SCANNER_BLANKING_GAP_EN
      if (t == 2) begin
        n_checks++;
        if (anodes_obs[0] !== 8'hFE) begin
          n_fail++; $display("FAIL restart_index0: got %h expected fe", anodes_obs[0]);
        end
      end
`endif
    end
    $display("mid_frame_reset: reset during digit 5, rescan from digit 0");
  endtask

  task automatic test_random();
    restart();
    repeat (4000) begin
      if ($urandom_range(0, 39) == 0) number = $urandom;
      if ($urandom_range(0, 59) == 0) digit_enable = 8'($urandom);
      if ($urandom_range(0, 59) == 0) dots = 8'($urandom);
      reset = ($urandom_range(0, 999) == 0);
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({anodes_obs[k], seg_obs[k], dp_obs[k], fs_obs[k]} !== {exp_an[k], exp_seg[k], exp_dp[k], exp_fs[k]}) begin
          n_fail++;
          $display("FAIL random dc=%0d t=%0d: got an=%h seg=%b dp=%b fs=%b, expected an=%h seg=%b dp=%b fs=%b",
                   dcs[k], t, anodes_obs[k], seg_obs[k], dp_obs[k], fs_obs[k],
                   exp_an[k], exp_seg[k], exp_dp[k], exp_fs[k]);
        end
      end
    end
    reset = 1'b0;
    $display("random: 4000 clocks with random inputs and resets");
  endtask

  initial begin
    dec_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    test_reset();
    test_first_load();
    test_scan_order();
    test_tearing();
    test_enables_dots();
    test_mid_frame_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
